// File: rtl/vram_write_arbiter_pkg.sv
// Shared state/target encodings and the budget counter width for the VRAM write arbiter.
package vram_arb_pkg;

    localparam int BUDGET_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_OPEN       = 2'd1,
        ST_EXHAUSTED  = 2'd2
    } arb_state_t;

    typedef enum logic {
        TGT_BG  = 1'b0,
        TGT_OAM = 1'b1
    } tgt_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Requester bus and the two RAM write ports shared through the VRAM write arbiter.
interface vram_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 39
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_tgt;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;

    logic                      bg_wea;
    logic [ADDR_W-1:0]         bg_addr;
    logic [DATA_W-1:0]         bg_din;
    logic                      oam_wea;
    logic [ADDR_W-1:0]         oam_addr;
    logic [DATA_W-1:0]         oam_din;

    modport master (
        output req, req_tgt, req_addr, req_data,
        input  ack, bg_wea, bg_addr, bg_din, oam_wea, oam_addr, oam_din
    );

    modport slave (
        input  req, req_tgt, req_addr, req_data,
        output ack, bg_wea, bg_addr, bg_din, oam_wea, oam_addr, oam_din
    );

endinterface

// File: rtl/vram_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, as a one-hot.
module rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic                       valid
);

    logic [NUM_REQ-1:0]   rotated;
    logic [NUM_REQ-1:0]   first;
    logic [2*NUM_REQ-1:0] spread;
    logic                 found;

    // Rotate rr_ptr down to bit 0, take the lowest set bit, then rotate it back into place.
    always_comb begin
        rotated = NUM_REQ'({eligible, eligible} >> rr_ptr);
        first   = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rotated[k] && !found) begin
                first[k] = 1'b1;
                found    = 1'b1;
            end
        end
        spread = {{NUM_REQ{1'b0}}, first} << rr_ptr;
        winner = spread[NUM_REQ-1:0] | spread[2*NUM_REQ-1:NUM_REQ];
        valid  = |eligible;
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the bg_ram/oam write ports under a per-frame write budget.
// Define VRAM_VBLANK_ONLY_EN to allow grants only while video_on is low.
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 39,
    parameter int WRITE_BUDGET = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                f_tick,
    input  logic                video_on,
    vram_write_arbiter_if.slave bus,
    output logic [BUDGET_W-1:0] budget_left,
    output logic [1:0]          state
);

    localparam int                  PTR_W         = $clog2(NUM_REQ);
    localparam logic [BUDGET_W-1:0] BUDGET_RELOAD = BUDGET_W'(WRITE_BUDGET);

    arb_state_t          cur_state;
    arb_state_t          next_state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [BUDGET_W-1:0] budget_eff;
    logic [BUDGET_W-1:0] budget_next;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  winner;
    logic                pick_valid;
    logic                gate_ok;
    logic                grant;
    tgt_t                sel_tgt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

`ifdef VRAM_VBLANK_ONLY_EN
    assign gate_ok = ~video_on;
`else
    logic unused_video_on;
    assign unused_video_on = video_on;
    assign gate_ok         = 1'b1;
`endif

    // A requester acked last cycle may still show req high; skip it to avoid a double write.
    assign eligible = bus.req & ~bus.ack;
    assign state    = cur_state;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .valid    (pick_valid)
    );

    // f_tick reloads first, so a grant in the same cycle spends from the fresh budget.
    always_comb begin
        budget_eff  = f_tick ? BUDGET_RELOAD : budget_left;
        grant       = pick_valid && gate_ok && (budget_eff != '0)
                      && (f_tick || (cur_state == ST_OPEN));
        next_state  = cur_state;
        budget_next = budget_eff;
        if (f_tick) begin
            next_state = ST_OPEN;
        end
        if (grant) begin
            budget_next = budget_eff - BUDGET_W'(1);
            if (budget_eff == BUDGET_W'(1)) begin
                next_state = ST_EXHAUSTED;
            end
        end
    end

    always_comb begin
        sel_tgt     = TGT_BG;
        sel_addr    = '0;
        sel_data    = '0;
        rr_ptr_next = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                sel_tgt  = tgt_t'(bus.req_tgt[i]);
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                if (grant) begin
                    rr_ptr_next = PTR_W'((i + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cur_state   <= ST_WAIT_FRAME;
            budget_left <= '0;
            rr_ptr      <= '0;
        end else begin
            cur_state   <= next_state;
            budget_left <= budget_next;
            rr_ptr      <= rr_ptr_next;
        end
    end

    // Address/data registers only load on a write so the RAM ports stay quiet otherwise.
    always_ff @(posedge clk) begin
        if (clr) begin
            bus.ack      <= '0;
            bus.bg_wea   <= 1'b0;
            bus.oam_wea  <= 1'b0;
            bus.bg_addr  <= '0;
            bus.bg_din   <= '0;
            bus.oam_addr <= '0;
            bus.oam_din  <= '0;
        end else begin
            bus.ack     <= grant ? winner : '0;
            bus.bg_wea  <= grant && (sel_tgt == TGT_BG);
            bus.oam_wea <= grant && (sel_tgt == TGT_OAM);
            if (grant && (sel_tgt == TGT_BG)) begin
                bus.bg_addr <= sel_addr;
                bus.bg_din  <= sel_data;
            end
            if (grant && (sel_tgt == TGT_OAM)) begin
                bus.oam_addr <= sel_addr;
                bus.oam_din  <= sel_data;
            end
        end
    end

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Shares the single write port of the background tile RAM (bg_ram) and the object attribute RAM (oam) among several requesters, such as the game engine, the scroll updater and the splash loader. It grants one write per cycle using round-robin priority. A per-frame write budget, reloaded on f_tick, stops the engines from starving each other. An optional gate restricts writes to the blanking interval. The block sits between the engines and the RAM write ports in the top level and replaces the shared bg_wea strobe.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, RAM write address width
- DATA_W, 39, write data width; bg_ram uses bits [8:0], oam uses bits [31:0]
- WRITE_BUDGET, 64, maximum grants per frame (1..255)

Ports:
- clk  in  1  system clock; one clock domain
- clr  in  1  reset, synchronous, active-high
- f_tick  in  1  one-cycle pulse at frame start
- video_on  in  1  high during the visible region
- req  in  NUM_REQ  per-requester write request
- req_tgt  in  NUM_REQ  per-requester target: 0 = bg_ram, 1 = oam
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  flattened data, sliced the same way
- ack  out  NUM_REQ  one-hot, one-cycle grant/completion pulse
- bg_wea, bg_addr, bg_din  out  1/ADDR_W/DATA_W  bg_ram write port
- oam_wea, oam_addr, oam_din  out  1/ADDR_W/DATA_W  oam write port
- budget_left  out  8  grants remaining in the current frame
- state  out  2  FSM state, for debug

## Operation
- FSM states:
  - WAIT_FRAME (0): the reset state; no grants.
  - OPEN (1): grants allowed.
  - EXHAUSTED (2): budget is 0; no grants.
- Transitions:
  - f_tick moves the FSM from any state to OPEN and sets budget_left = WRITE_BUDGET.
  - OPEN moves to EXHAUSTED when a grant brings budget_left to 0.
- Eligible requesters: req[i] = 1 and ack[i] = 0 in the current cycle. This blocks a double grant while the requester is still dropping req.
- Grant permitted when:
  - state is OPEN, or f_tick is high this cycle, and
  - budget_left (after any reload) is nonzero, and
  - the blanking gate passes (see Configuration).
- Round-robin pick:
  - A pointer rr_ptr resets to 0.
  - The first eligible index at or after rr_ptr, modulo NUM_REQ, wins.
  - After a grant to index i, rr_ptr becomes (i+1) mod NUM_REQ.
  - With no grant, rr_ptr is held.
- On a grant to i:
  - Register ack[i] = 1.
  - Assert the write port selected by req_tgt[i]. Its wea = 1, addr = slice i, din = slice i.
  - The other port's wea = 0.
  - budget_left decrements by 1.
- Handshake: a requester holds req, tgt, addr and data stable until it sees ack. It may re-raise req in the cycle after ack.
- When f_tick and a grant occur in the same cycle, the reload takes effect first and the grant consumes from it: budget_left = WRITE_BUDGET-1.
- addr and din registers hold their last values when wea = 0.
- At most one of bg_wea and oam_wea is high in any cycle.

## Timing
- Reset values (clr sampled high at a clk edge):
  - state = WAIT_FRAME, budget_left = 0, rr_ptr = 0
  - ack = 0, bg_wea = oam_wea = 0
  - all addr and din outputs = 0
- clr takes priority over f_tick and req.
- Reset in the middle of a write: wea and ack drop at the next edge and no partial write is retried.
- Latency: req sampled at edge N produces ack, wea, addr and din valid after edge N, so the RAM captures the write at edge N+1.
- Throughput: one write per cycle across distinct requesters. A single requester gets at most one write every 2 cycles.

## Configuration
- VRAM_VBLANK_ONLY_EN defined: a grant additionally requires video_on = 0. Requests made during the visible region wait until blanking. Budget and FSM behaviour are unchanged.
- VRAM_VBLANK_ONLY_EN undefined: video_on is ignored for grant decisions (the port remains).

## Structure
- Package vram_arb_pkg:
  - state encodings ST_WAIT_FRAME=0, ST_OPEN=1, ST_EXHAUSTED=2
  - target encodings TGT_BG=0, TGT_OAM=1
  - the budget counter width (8)
- Sub-module rr_pick, purely combinational:
  - inputs: eligible vector and rr_ptr
  - outputs: a one-hot winner and a valid flag
  - instantiated once.

## Test plan
- Reset, then req[0]=1 with tgt 0, addr 0x0010, data 0x1AB, and no f_tick → ack stays 0 and state=0. After an f_tick pulse → ack[0] for one cycle, bg_wea=1, bg_addr=0x0010, bg_din=0x1AB, budget_left=63.
- req = 3'b111 held continuously after f_tick → ack sequence 001, 010, 100, 001 on consecutive cycles.
- WRITE_BUDGET=4, single requester holding req → exactly 4 acks, state=2, budget_left=0. The next f_tick restores grants.
- f_tick and a pending req in the same cycle while in EXHAUSTED → grant issued, budget_left=WRITE_BUDGET-1, state=1.
- With VRAM_VBLANK_ONLY_EN defined, oam request with tgt 1 while video_on=1 → no oam_wea until video_on=0, then oam_wea=1 for one cycle.
- clr asserted in the cycle after a grant → ack=0, wea=0, state=0, and no second write.
